// File: rtl/booth_radix4_seq_mult_if.sv
// Multiplier request/result bundle between the ALU control (master) and the Booth multiplier (slave).
// Operands and mode travel with Start; Busy/Done/Hi/Lo/BoothSel return from the multiplier.
interface booth_radix4_seq_mult_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [2:0]       BoothSel;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, BoothSel, Hi, Lo
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, BoothSel, Hi, Lo
  );
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier (mult/multu): one Booth digit per clock, WIDTH/2+1 steps.
// Start->Done is WIDTH/2+2 cycles; Start is ignored while Busy, Start in the DONE cycle chains a new op.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  booth_radix4_seq_mult_if.slave  bus
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;
  localparam int PW = WIDTH + 4;
  localparam int SW = PW + XW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          stateNext;

  logic [XW-1:0]   mReg;
  logic [XW-1:0]   qReg;
  logic            qm1;
  logic [PW-1:0]   pReg;
  logic [CW-1:0]   stepCnt;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic [2:0]      triplet;
  logic [PW-1:0]   mExt;
  logic [PW-1:0]   m2Ext;
  logic [PW-1:0]   ppSel;
  logic [PW-1:0]   pSum;
  logic [SW-1:0]   shifted;
  logic [PW-1:0]   pNext;
  logic [XW-1:0]   qNext;
  logic            qm1Next;
  logic [XW-1:0]   aExt;
  logic [XW-1:0]   bExt;
  logic            lastStep;
  logic            capture;
  logic            busyNext;
  logic            doneNext;
  logic [2:0]      selNext;

  assign triplet = {qReg[1], qReg[0], qm1};
  assign mExt    = {{2{mReg[XW-1]}}, mReg};
  assign m2Ext   = {mExt[PW-2:0], 1'b0};

  always_comb begin
    ppSel = '0;
    case (triplet)
      3'b001, 3'b010: ppSel = mExt;
      3'b011:         ppSel = m2Ext;
      3'b100:         ppSel = -m2Ext;
      3'b101, 3'b110: ppSel = -mExt;
      default:        ppSel = '0;
    endcase
  end

  // Accumulate, then shift {P,Q,Q-1} right by one Booth digit keeping P's sign.
  assign pSum    = pReg + ppSel;
  assign shifted = $signed({pSum, qReg, qm1}) >>> 2;
  assign {pNext, qNext, qm1Next} = shifted;

  assign aExt = {{2{bus.Signed & bus.A[WIDTH-1]}}, bus.A};
  assign bExt = {{2{bus.Signed & bus.B[WIDTH-1]}}, bus.B};

  assign lastStep = (stepCnt == CW'(N - 1));
  assign capture  = bus.Start && (state != RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    selNext   = 3'b000;
    case (state)
      IDLE: begin
        if (bus.Start) stateNext = RUN;
      end
      RUN: begin
        busyNext = 1'b1;
        selNext  = triplet;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        doneNext  = 1'b1;
        stateNext = bus.Start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.Busy     = busyNext;
  assign bus.Done     = doneNext;
  assign bus.BoothSel = selNext;
  assign bus.Hi       = hiReg;
  assign bus.Lo       = loReg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mReg    <= '0;
      qReg    <= '0;
      qm1     <= 1'b0;
      pReg    <= '0;
      stepCnt <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else if (capture) begin
      mReg    <= aExt;
      qReg    <= bExt;
      qm1     <= 1'b0;
      pReg    <= '0;
      stepCnt <= '0;
    end else if (state == RUN) begin
      pReg    <= pNext;
      qReg    <= qNext;
      qm1     <= qm1Next;
      stepCnt <= stepCnt + 1'b1;
      // After the final shift the multiplier has left Q entirely; low 2*WIDTH bits of {P,Q} are the product.
      if (lastStep) begin
        loReg <= qNext[WIDTH-1:0];
        hiReg <= {pNext[WIDTH-3:0], qNext[XW-1:WIDTH]};
      end
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed tests for booth_radix4_seq_mult: products, handshake timing, BoothSel trace and reset abort.
module tb_booth_radix4_seq_mult;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  booth_radix4_seq_mult_if #(.WIDTH(32)) bus ();

  booth_radix4_seq_mult #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Launches one op from the current cycle and waits for Done; reports timing, no checking here.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int edges, output int busyCnt, output bit timeout);
    bus.Start  = 1'b1;
    bus.Signed = sgn;
    bus.A      = a;
    bus.B      = b;
    edges   = 0;
    busyCnt = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      edges++;
      if (edges == 1) bus.Start = 1'b0;
      if (bus.Busy === 1'b1) busyCnt++;
      if (bus.Done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    hi = bus.Hi;
    lo = bus.Lo;
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    checks++; if (bus.BoothSel !== 3'b000) begin fails++; $display("FAIL reset_boothsel got=%b exp=000", bus.BoothSel); end
    checks++; if (bus.Hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", bus.Hi); end
    checks++; if (bus.Lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", bus.Lo); end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_signed_small;
    logic [31:0] hi, lo; int edges, busyCnt; bit to;
    do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, hi, lo, edges, busyCnt, to);
    checks++; if (to) begin fails++; $display("FAIL small_timeout got=no_done exp=done"); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL small_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL small_lo got=%h exp=ffffffeb", lo); end
    checks++; if (edges != 18) begin fails++; $display("FAIL small_latency got=%0d exp=18", edges); end
    checks++; if (busyCnt != 17) begin fails++; $display("FAIL small_busy_cycles got=%0d exp=17", busyCnt); end
    @(posedge Clk); #1;
    checks++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL small_done_pulse got=%b exp=0", bus.Done); end
    checks++; if (bus.Lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL small_lo_hold got=%h exp=ffffffeb", bus.Lo); end
  endtask

  task automatic test_all_ones;
    logic [31:0] hi, lo; int edges, busyCnt; bit to;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, edges, busyCnt, to);
    checks++; if (to) begin fails++; $display("FAIL ones_u_timeout got=no_done exp=done"); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL ones_u_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL ones_u_lo got=%h exp=00000001", lo); end
    @(posedge Clk); #1;
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, edges, busyCnt, to);
    checks++; if (to) begin fails++; $display("FAIL ones_s_timeout got=no_done exp=done"); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL ones_s_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'h1) begin fails++; $display("FAIL ones_s_lo got=%h exp=00000001", lo); end
    @(posedge Clk); #1;
  endtask

  task automatic test_min_values;
    logic [31:0] hi, lo; int edges, busyCnt; bit to;
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, hi, lo, edges, busyCnt, to);
    checks++; if (to) begin fails++; $display("FAIL min2_timeout got=no_done exp=done"); end
    checks++; if (hi !== 32'h4000_0000) begin fails++; $display("FAIL min2_hi got=%h exp=40000000", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL min2_lo got=%h exp=00000000", lo); end
    @(posedge Clk); #1;
    do_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, hi, lo, edges, busyCnt, to);
    checks++; if (to) begin fails++; $display("FAIL minmax_timeout got=no_done exp=done"); end
    checks++; if (hi !== 32'hC000_0000) begin fails++; $display("FAIL minmax_hi got=%h exp=c0000000", hi); end
    checks++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL minmax_lo got=%h exp=80000000", lo); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back;
    int edges;
    bit seen;
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'h0000_1234; bus.B = 32'h0000_0010;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      edges++;
      if (edges == 1) begin bus.A = '0; bus.B = '0; end
      if (bus.Done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || edges != 18) begin fails++; $display("FAIL b2b_first_latency got=%0d exp=18", edges); end
    checks++; if (bus.Lo !== 32'h0001_2340) begin fails++; $display("FAIL b2b_first_lo got=%h exp=00012340", bus.Lo); end
    checks++; if (bus.Hi !== 32'h0) begin fails++; $display("FAIL b2b_first_hi got=%h exp=00000000", bus.Hi); end
    // Start is still high in this DONE cycle, so these operands open the second op.
    bus.A = 32'd9; bus.B = 32'd11;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      edges++;
      if (edges == 1) bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || edges != 18) begin fails++; $display("FAIL b2b_second_latency got=%0d exp=18", edges); end
    checks++; if (bus.Lo !== 32'd99) begin fails++; $display("FAIL b2b_second_lo got=%h exp=00000063", bus.Lo); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_abort;
    logic [31:0] hi, lo; int edges, busyCnt, doneSeen; bit to;
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'h0000_FFFF; bus.B = 32'h0000_FFFF;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (7) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", bus.Done); end
    checks++; if (bus.Hi !== 32'h0) begin fails++; $display("FAIL abort_hi got=%h exp=0", bus.Hi); end
    checks++; if (bus.Lo !== 32'h0) begin fails++; $display("FAIL abort_lo got=%h exp=0", bus.Lo); end
    checks++; if (bus.BoothSel !== 3'b000) begin fails++; $display("FAIL abort_boothsel got=%b exp=000", bus.BoothSel); end
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (bus.Done !== 1'b0) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", doneSeen); end
    Reset_n = 1'b1;
    do_op(1'b0, 32'd3, 32'd5, hi, lo, edges, busyCnt, to);
    checks++; if (to || edges != 18) begin fails++; $display("FAIL post_reset_latency got=%0d exp=18", edges); end
    checks++; if (lo !== 32'd15) begin fails++; $display("FAIL post_reset_lo got=%h exp=0000000f", lo); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL post_reset_hi got=%h exp=00000000", hi); end
    @(posedge Clk); #1;
  endtask

  task automatic test_booth_sel;
    int badIdle;
    bit seen;
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd1; bus.B = 32'd6;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    checks++; if (bus.BoothSel !== 3'b100) begin fails++; $display("FAIL sel_cycle1 got=%b exp=100", bus.BoothSel); end
    @(posedge Clk); #1;
    checks++; if (bus.BoothSel !== 3'b011) begin fails++; $display("FAIL sel_cycle2 got=%b exp=011", bus.BoothSel); end
    badIdle = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (bus.BoothSel !== 3'b000) badIdle++;
      if (bus.Done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (badIdle != 0) begin fails++; $display("FAIL sel_remaining got=%0d nonzero exp=0", badIdle); end
    checks++; if (!seen) begin fails++; $display("FAIL sel_timeout got=no_done exp=done"); end
    checks++; if (bus.Lo !== 32'd6) begin fails++; $display("FAIL sel_lo got=%h exp=00000006", bus.Lo); end
    checks++; if (bus.Hi !== 32'h0) begin fails++; $display("FAIL sel_hi got=%h exp=00000000", bus.Hi); end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_signed_small();
    test_all_ones();
    test_min_values();
    test_back_to_back();
    test_reset_abort();
    test_booth_sel();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
